// File: rtl/fir_coeff_scheduler.sv
// ---------------------------------------------------------------------------
// fir_coeff_scheduler
//
// Purpose:
//   Sequences coefficient-set changes for the reconfigurable FIR. Sits in
//   front of the FIR's input AXI-Stream slave and owns the FIR's coeff_sel.
//   Two requesters (PS register path on req0, demod controller on req1)
//   submit coefficient-set selections, which are arbitrated round-robin.
//   A selection is only applied between packets. After a real change the
//   input stream is held off for SETTLE_CYCLES cycles while the FIR reloads
//   its taps.
//
// Ports:
//   aclk, areset           clock, synchronous active-high reset
//   req0_valid/sel/ready   requester 0 selection; ready is a one-cycle accept
//   req1_valid/sel/ready   requester 1 selection; ready is a one-cycle accept
//   s_axis_*               upstream AXI-Stream slave (samples in)
//   m_axis_*               AXI-Stream master towards the FIR's s00 port
//   coeff_sel              registered coefficient-set select to the FIR
//   busy                   high while the FIR is settling after a change
//   switch_count           number of effective switches, wraps 255 -> 0
// ---------------------------------------------------------------------------
module fir_coeff_scheduler #(
    parameter int DATA_WIDTH      = 16,
    parameter int COEFF_SEL_WIDTH = 4,
    parameter int DEFAULT_SEL     = 0,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic                       aclk,
    input  logic                       areset,

    input  logic                       req0_valid,
    input  logic [COEFF_SEL_WIDTH-1:0] req0_sel,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [COEFF_SEL_WIDTH-1:0] req1_sel,
    output logic                       req1_ready,

    input  logic                       s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,

    output logic                       m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,

    output logic [COEFF_SEL_WIDTH-1:0] coeff_sel,
    output logic                       busy,
    output logic [7:0]                 switch_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [COEFF_SEL_WIDTH-1:0] SEL_RESET = COEFF_SEL_WIDTH'(DEFAULT_SEL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PKT    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_ptr;          // 0: favour req0, 1: favour req1
    logic [COEFF_SEL_WIDTH-1:0] r_coeff_sel;
    logic [7:0]                 r_switch_count;
    logic [CNT_W-1:0]           r_settle;
    logic                       r_busy;

    logic                       w_idle;
    logic                       w_grant0;
    logic                       w_grant1;
    logic                       w_grant;
    logic                       w_gate;
    logic                       w_beat;
    logic [COEFF_SEL_WIDTH-1:0] w_sel;

    // Grants only happen between packets. With both requesters pending the
    // pointer decides; a lone requester is granted regardless of the pointer.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_grant0 = w_idle & req0_valid & (~req1_valid | ~r_ptr);
    assign w_grant1 = w_idle & req1_valid & (~req0_valid |  r_ptr);
    assign w_grant  = w_grant0 | w_grant1;
    assign w_sel    = w_grant1 ? req1_sel : req0_sel;

    // The stream is blocked during settling and also in the grant cycle
    // itself, so a grant always wins over a same-cycle data beat and no
    // sample can slip through under the old coefficient set.
    assign w_gate = (r_state != ST_SWITCH) & ~w_grant;
    assign w_beat = s_axis_tvalid & m_axis_tready & w_gate;

    assign m_axis_tvalid = s_axis_tvalid & w_gate;
    assign s_axis_tready = m_axis_tready & w_gate;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;

    assign req0_ready   = w_grant0;
    assign req1_ready   = w_grant1;
    assign coeff_sel    = r_coeff_sel;
    assign busy         = r_busy;
    assign switch_count = r_switch_count;

    // Main sequencer. Packet tracking, arbitration pointer, coefficient
    // select and settle timing all advance together here. After every grant
    // the pointer moves to the other requester so a requester that keeps
    // asking cannot starve its peer.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state        <= ST_IDLE;
            r_ptr          <= 1'b0;
            r_coeff_sel    <= SEL_RESET;
            r_switch_count <= 8'd0;
            r_settle       <= '0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_ptr <= w_grant0;
                        if (w_sel != r_coeff_sel) begin
                            r_coeff_sel    <= w_sel;
                            r_switch_count <= r_switch_count + 8'd1;
                            r_settle       <= '0;
                            r_busy         <= 1'b1;
                            r_state        <= ST_SWITCH;
                        end
                    end else if (w_beat && !s_axis_tlast) begin
                        r_state <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (w_beat && s_axis_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SWITCH: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_settle <= r_settle + CNT_W'(1);
                    end
                end
                default: begin
                    r_settle <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_scheduler
//
// Purpose:
//   Directed self-checking bench for fir_coeff_scheduler. Each scenario task
//   drives its own stimulus and compares DUT outputs against hand-computed
//   values. Inputs change 1 ns after a rising edge and outputs are sampled
//   1 ns later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_fir_coeff_scheduler;

    logic        aclk;
    logic        areset;
    logic        req0_valid;
    logic [3:0]  req0_sel;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_sel;
    logic        req1_ready;
    logic        s_axis_tvalid;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [3:0]  coeff_sel;
    logic        busy;
    logic [7:0]  switch_count;

    int compared;
    int mismatched;

    fir_coeff_scheduler #(
        .DATA_WIDTH      (16),
        .COEFF_SEL_WIDTH (4),
        .DEFAULT_SEL     (0),
        .SETTLE_CYCLES   (4)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .req0_valid    (req0_valid),
        .req0_sel      (req0_sel),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_sel      (req1_sel),
        .req1_ready    (req1_ready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .coeff_sel     (coeff_sel),
        .busy          (busy),
        .switch_count  (switch_count)
    );

    // 100 MHz clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance to 1 ns after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Puts the DUT back into its reset state with all inputs idle.
    task automatic do_reset();
        areset        = 1'b1;
        req0_valid    = 1'b0;
        req0_sel      = 4'd0;
        req1_valid    = 1'b0;
        req1_sel      = 4'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'h0000;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        cyc();
        cyc();
        areset = 1'b0;
    endtask

    // Single req0 switch to sel; returns in the first IDLE cycle after settle.
    task automatic do_switch(input logic [3:0] sel);
        cyc();
        req0_valid = 1'b1;
        req0_sel   = sel;
        cyc();
        req0_valid = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        do_reset();
        areset = 1'b1;
        cyc();
        #1;
        compared++;
        if (coeff_sel !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_coeff_sel got=%0d exp=0", coeff_sel);
        end
        compared++;
        if (switch_count !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_switch_count got=%0d exp=0", switch_count);
        end
        compared++;
        if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags busy=%b r0=%b r1=%b exp=000", busy, req0_ready, req1_ready);
        end
        compared++;
        if (s_axis_tready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_gate s_tready=%b exp=1", s_axis_tready);
        end
        areset = 1'b0;
    endtask

    // Request in IDLE: 1-cycle ready, busy for 4 cycles, 5 stalled cycles.
    task automatic test_single_switch();
        logic expReady;
        logic expBusy;
        logic expTready;
        do_reset();
        cyc();
        req0_valid = 1'b1;
        req0_sel   = 4'd2;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                cyc();
                if (k == 1) req0_valid = 1'b0;
                #1;
            end
            expReady  = (k == 0);
            expBusy   = (k >= 1 && k <= 4);
            expTready = (k == 5);
            compared++;
            if (req0_ready !== expReady) begin
                mismatched++;
                $display("[TB] FAIL single_ready k=%0d got=%b exp=%b", k, req0_ready, expReady);
            end
            compared++;
            if (busy !== expBusy) begin
                mismatched++;
                $display("[TB] FAIL single_busy k=%0d got=%b exp=%b", k, busy, expBusy);
            end
            compared++;
            if (s_axis_tready !== expTready) begin
                mismatched++;
                $display("[TB] FAIL single_tready k=%0d got=%b exp=%b", k, s_axis_tready, expTready);
            end
            if (k == 1) begin
                compared++;
                if (coeff_sel !== 4'd2 || switch_count !== 8'd1) begin
                    mismatched++;
                    $display("[TB] FAIL single_update sel=%0d cnt=%0d exp sel=2 cnt=1", coeff_sel, switch_count);
                end
            end
        end
    endtask

    // Request raised mid-packet waits until the cycle after the tlast beat.
    task automatic test_packet_boundary();
        logic [15:0] words [4];
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = words[i];
            s_axis_tlast  = (i == 3);
            if (i == 1) begin
                req1_valid = 1'b1;
                req1_sel   = 4'd5;
            end
            #1;
            compared++;
            if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b1 || m_axis_tdata !== words[i]
                || m_axis_tlast !== (i == 3)) begin
                mismatched++;
                $display("[TB] FAIL pkt_beat i=%0d v=%b r=%b d=%h l=%b exp v=1 r=1 d=%h", i,
                         m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tlast, words[i]);
            end
            compared++;
            if (req1_ready !== 1'b0 || coeff_sel !== 4'd0) begin
                mismatched++;
                $display("[TB] FAIL pkt_hold i=%0d ready=%b sel=%0d exp ready=0 sel=0", i, req1_ready, coeff_sel);
            end
        end
        cyc();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #1;
        compared++;
        if (req1_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL pkt_grant_after_last got=%b exp=1", req1_ready);
        end
        cyc();
        req1_valid = 1'b0;
        #1;
        compared++;
        if (coeff_sel !== 4'd5 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL pkt_switch sel=%0d busy=%b exp sel=5 busy=1", coeff_sel, busy);
        end
        repeat (4) cyc();
    endtask

    // Contention: req0 first, req1 after settle, then req0 first again.
    task automatic test_round_robin();
        do_reset();
        cyc();
        req0_valid = 1'b1;
        req0_sel   = 4'd3;
        req1_valid = 1'b1;
        req1_sel   = 4'd7;
        #1;
        compared++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rr_first r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        cyc();
        req0_valid = 1'b0;
        #1;
        compared++;
        if (coeff_sel !== 4'd3 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rr_first_sel sel=%0d busy=%b exp sel=3 busy=1", coeff_sel, busy);
        end
        for (int k = 2; k <= 4; k++) begin
            cyc();
            #1;
            compared++;
            if (req1_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rr_wait k=%0d r1=%b exp=0", k, req1_ready);
            end
        end
        cyc();
        #1;
        compared++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rr_second r0=%b r1=%b exp r0=0 r1=1", req0_ready, req1_ready);
        end
        cyc();
        req1_valid = 1'b0;
        #1;
        compared++;
        if (coeff_sel !== 4'd7 || switch_count !== 8'd2) begin
            mismatched++;
            $display("[TB] FAIL rr_final sel=%0d cnt=%0d exp sel=7 cnt=2", coeff_sel, switch_count);
        end
        repeat (4) cyc();
        req0_valid = 1'b1;
        req0_sel   = 4'd1;
        req1_valid = 1'b1;
        req1_sel   = 4'd4;
        #1;
        compared++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rr_again r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) cyc();
    endtask

    // Request for the already-active set: accepted, no switch, 1-cycle stall.
    task automatic test_same_sel();
        do_reset();
        cyc();
        req0_valid    = 1'b1;
        req0_sel      = 4'd0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hAAAA;
        s_axis_tlast  = 1'b1;
        #1;
        compared++;
        if (req0_ready !== 1'b1 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL same_grant ready=%b s_tready=%b m_tvalid=%b exp 1 0 0",
                     req0_ready, s_axis_tready, m_axis_tvalid);
        end
        cyc();
        req0_valid = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || switch_count !== 8'd0 || coeff_sel !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL same_nochange busy=%b cnt=%0d sel=%0d exp 0 0 0", busy, switch_count, coeff_sel);
        end
        compared++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL same_reopen s_tready=%b m_tvalid=%b exp 1 1", s_axis_tready, m_axis_tvalid);
        end
        cyc();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Grant beats a same-cycle first beat; data resumes intact after settle.
    task automatic test_back_to_back();
        logic [15:0] got [4];
        int          nGot;
        int          idx;
        int          budget;
        do_reset();
        nGot = 0;
        idx  = 0;
        cyc();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hB000;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        req0_valid    = 1'b1;
        req0_sel      = 4'd6;
        #1;
        compared++;
        if (req0_ready !== 1'b1 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_grant_wins ready=%b m_tvalid=%b s_tready=%b exp 1 0 0",
                     req0_ready, m_axis_tvalid, s_axis_tready);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 1) req0_valid = 1'b0;
            m_axis_tready = k[0];
            #1;
            compared++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL b2b_settle k=%0d s_tready=%b m_tvalid=%b exp 0 0", k, s_axis_tready, m_axis_tvalid);
            end
        end
        budget = 0;
        while (nGot < 4 && budget < 40) begin
            cyc();
            budget++;
            m_axis_tready = budget[0];
            s_axis_tdata  = 16'hB000 + 16'(idx);
            s_axis_tlast  = (idx == 3);
            #1;
            compared++;
            if (m_axis_tvalid !== 1'b1 || s_axis_tready !== m_axis_tready) begin
                mismatched++;
                $display("[TB] FAIL b2b_flow cyc=%0d m_tvalid=%b s_tready=%b exp 1 %b",
                         budget, m_axis_tvalid, s_axis_tready, m_axis_tready);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got[nGot] = m_axis_tdata;
                nGot++;
                idx++;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        compared++;
        if (nGot != 4) begin
            mismatched++;
            $display("[TB] FAIL b2b_count got=%0d exp=4", nGot);
        end
        for (int i = 0; i < nGot; i++) begin
            compared++;
            if (got[i] !== 16'hB000 + 16'(i)) begin
                mismatched++;
                $display("[TB] FAIL b2b_data i=%0d got=%h exp=%h", i, got[i], 16'hB000 + 16'(i));
            end
        end
        compared++;
        if (coeff_sel !== 4'd6) begin
            mismatched++;
            $display("[TB] FAIL b2b_sel got=%0d exp=6", coeff_sel);
        end
    endtask

    // Reset in the middle of SWITCH and in the middle of a packet.
    task automatic test_reset_midflight();
        do_reset();
        do_switch(4'd1);
        do_switch(4'd2);
        req0_valid = 1'b1;
        req0_sel   = 4'd9;
        cyc();
        req0_valid = 1'b0;
        #1;
        compared++;
        if (coeff_sel !== 4'd9 || switch_count !== 8'd3 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_pre sel=%0d cnt=%0d busy=%b exp 9 3 1", coeff_sel, switch_count, busy);
        end
        cyc();
        areset = 1'b1;
        cyc();
        areset = 1'b0;
        #1;
        compared++;
        if (coeff_sel !== 4'd0 || switch_count !== 8'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_switch sel=%0d cnt=%0d busy=%b exp 0 0 0", coeff_sel, switch_count, busy);
        end
        compared++;
        if (s_axis_tready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_gate s_tready=%b exp=1", s_axis_tready);
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hC0DE;
        s_axis_tlast  = 1'b0;
        cyc();
        s_axis_tvalid = 1'b0;
        areset        = 1'b1;
        cyc();
        areset     = 1'b0;
        req1_valid = 1'b1;
        req1_sel   = 4'd3;
        #1;
        compared++;
        if (req1_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_pkt_idle r1=%b exp=1", req1_ready);
        end
        cyc();
        req1_valid = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        do_reset();
        test_reset();
        test_single_switch();
        test_packet_boundary();
        test_round_robin();
        test_same_sel();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fir_coeff_scheduler.md
Name: fir_coeff_scheduler

Overview:
Sequences coefficient-set changes for the reconfigurable FIR. It sits in front of the FIR's input AXI-Stream slave and drives its coeff_sel. Two requesters (PS register path, demod controller) submit coefficient-set selections; the block arbitrates them round-robin. A selection is applied only on a packet boundary, then input is held off for a settle window while the FIR reloads taps.

Parameters:
DATA_WIDTH, 16, AXI-Stream tdata width (pass-through)
COEFF_SEL_WIDTH, 4, width of coefficient-set select
DEFAULT_SEL, 0, coeff_sel value after reset
SETTLE_CYCLES, 4, hold-off cycles after a coeff_sel change (>=1)

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has a selection pending
req0_sel  in  COEFF_SEL_WIDTH  requester 0 selection
req0_ready  out  1  one-cycle grant/accept of req0
req1_valid  in  1  requester 1 has a selection pending
req1_sel  in  COEFF_SEL_WIDTH  requester 1 selection
req1_ready  out  1  one-cycle grant/accept of req1
s_axis_tvalid  in  1  upstream sample valid
s_axis_tdata  in  DATA_WIDTH  upstream sample
s_axis_tlast  in  1  upstream end of packet
s_axis_tready  out  1  upstream ready
m_axis_tvalid  out  1  to FIR s00 valid
m_axis_tdata  out  DATA_WIDTH  to FIR s00 data
m_axis_tlast  out  1  to FIR s00 last
m_axis_tready  in  1  FIR s00 ready
coeff_sel  out  COEFF_SEL_WIDTH  to FIR coefficient select (registered)
busy  out  1  high in SWITCH state
switch_count  out  8  number of effective switches, wraps 255->0

Behaviour:
- Clock aclk; reset areset is synchronous and active-high.
- Reset: state IDLE, coeff_sel=DEFAULT_SEL, switch_count=0, settle counter 0, round-robin pointer favours req0. Outputs: busy=0, req*_ready=0. Stream outputs follow the gating rule below.
- Stream pass-through is combinational. The gate is open iff not SWITCH and no grant occurs this cycle.
  - m_axis_tvalid = s_axis_tvalid & gate.
  - s_axis_tready = m_axis_tready & gate.
  - tdata and tlast are wired straight through.
- A beat is the handshake s_axis_tvalid & s_axis_tready.
- States:
  - IDLE: between packets.
    - A beat with tlast=0 -> PKT.
    - A beat with tlast=1 (single-beat packet) stays IDLE.
  - PKT: inside a packet. Requests are ignored (ready=0, requesters hold valid).
    - A beat with tlast=1 -> IDLE (the grant may occur the following cycle at the earliest).
  - SWITCH: gate closed. Settle counter counts SETTLE_CYCLES cycles, then -> IDLE.
- Grant (IDLE only, combinational ready):
  - If exactly one req valid, grant it.
  - If both valid, grant the one the pointer favours; the pointer then flips to the other requester.
  - The grant has precedence over a same-cycle data beat: the gate is closed, so no beat occurs.
- On the grant edge:
  - If granted sel != coeff_sel: coeff_sel <= sel, switch_count++, -> SWITCH. busy is high from the next cycle for exactly SETTLE_CYCLES cycles. The gate reopens SETTLE_CYCLES+1 cycles after the grant cycle.
  - If granted sel == coeff_sel: accepted, no count change, stay IDLE. The gate reopens the next cycle.
- Requesters must hold sel stable while valid. Dropping valid before ready withdraws the request.
- The m_axis_tready=0 backpressure does not affect state except through beats.
- areset asserted in any state (including mid-packet or mid-SWITCH) returns to the reset values at the next edge. The partially passed packet is not tracked after reset.

Test Plan:
1. Reset, then req0_valid=1, sel=2 in IDLE -> req0_ready pulses 1 cycle; coeff_sel=2 next cycle; busy high 4 cycles; switch_count=1; s_axis_tready low for 5 cycles total.
2. Four-beat packet 0x1111..0x4444 (tlast on 0x4444); raise req1 sel=5 after beat 1 -> no ready until after the tlast beat; all 4 beats pass unmodified with coeff_sel=DEFAULT; grant on the cycle after the tlast beat; coeff_sel=5.
3. req0 (sel=3) and req1 (sel=7) both valid in IDLE, held -> grant order req0, then req1 after its settle; final coeff_sel=7; switch_count=2; next simultaneous pair grants req0 first again.
4. req0 sel equal to current coeff_sel -> ready pulse, busy stays 0, switch_count unchanged, stream stalled exactly 1 cycle.
5. s_axis_tvalid held 1 with m_axis_tready toggling, and a request arriving the same cycle as the first beat in IDLE -> grant wins; no beat that cycle; data resumes after settle with no loss or duplication.
6. Assert areset mid-SWITCH (coeff_sel=9, switch_count=3) -> next cycle coeff_sel=0, switch_count=0, busy=0, state IDLE, gate open.
